cpu_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the cpu_top datapath (PC, IMEM, regfile, ALU, DMEM).

---
 rtl/cpu_multicycle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_cpu_multicycle_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle_ctrl.sv
// rtl/cpu_multicycle_ctrl.sv - multi-cycle instruction sequencer for the cpu_top datapath
//
// Purpose:
//   Steps each instruction through FETCH / DECODE / EXEC / MEM / WB and drives
//   every datapath enable and mux select. IMEM and DMEM are handshaken with
//   req/ack. An illegal instruction or a memory that never acknowledges parks
//   the controller in HALT with a sticky error code until RST.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   imem_ack          IMEM instruction valid this cycle
//   dmem_ack          DMEM read data valid / write accepted this cycle
//   opcode, funct     instr[31:26] and instr[5:0] from the IR
//   alu_zero          ALU result is zero (beq condition)
//   imem_req          instruction fetch request
//   dmem_req/dmem_we  data access request, 1=store 0=load
//   pc_we/pc_src      PC load enable; 0=PC+4 1=branch target 2=jump target
//   ir_we             latch instruction into IR
//   rf_we/reg_dst     regfile write enable; write address 0=rt 1=rd
//   mem_to_reg        regfile write data 0=ALU result 1=DMEM data
//   alu_src_b/alu_op  ALU B operand 0=rt 1=imm; op 0=ADD 1=SUB 2=AND 3=OR 4=SLT
//   halted/err_code   sticky stop; 0=none 1=illegal 2=imem timeout 3=dmem timeout
//   instret           retired-instruction count (wraps)

module cpu_multicycle_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             rf_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(WAIT_MAX) + 1;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_IMEM_TO = 2'd2;
  localparam logic [1:0] ERR_DMEM_TO = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_ADDI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J
  } cls_t;

  state_t            state, state_n;
  cls_t              cls_q;
  logic [2:0]        alu_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        err_q, err_n;
  logic              wait_inc;
  logic              retire;
  logic              wait_last;

  // Instruction decode, only consumed in DECODE where the IR is stable.
  logic       dec_ok;
  cls_t       dec_cls;
  logic [2:0] dec_alu;

  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_R;
    dec_alu = ALU_ADD;
    case (opcode)
      6'h00: begin
        dec_cls = C_R;
        case (funct)
          6'h20:   dec_alu = ALU_ADD;
          6'h22:   dec_alu = ALU_SUB;
          6'h24:   dec_alu = ALU_AND;
          6'h25:   dec_alu = ALU_OR;
          6'h2A:   dec_alu = ALU_SLT;
          default: dec_ok  = 1'b0;
        endcase
      end
      6'h08:   dec_cls = C_ADDI;
      6'h23:   dec_cls = C_LW;
      6'h2B:   dec_cls = C_SW;
      6'h04: begin
        dec_cls = C_BEQ;
        dec_alu = ALU_SUB;
      end
      6'h02:   dec_cls = C_J;
      default: dec_ok  = 1'b0;
    endcase
  end

  // The final permitted wait cycle: no ack here means the memory is dead.
  assign wait_last = (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  // Next-state logic
  always_comb begin
    state_n  = state;
    err_n    = err_q;
    wait_inc = 1'b0;
    retire   = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          state_n = S_DECODE;
        end else if (wait_last) begin
          state_n = S_HALT;
          err_n   = ERR_IMEM_TO;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (!dec_ok) begin
          state_n = S_HALT;
          err_n   = ERR_ILLEGAL;
        end else if (dec_cls == C_J) begin
          state_n = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_q == C_BEQ) begin
          state_n = S_FETCH;
          retire  = 1'b1;
        end else if (cls_q == C_R || cls_q == C_ADDI) begin
          state_n = S_WB;
        end else begin
          state_n = S_MEM;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (cls_q == C_SW) begin
            state_n = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_n = S_WB;
          end
        end else if (wait_last) begin
          state_n = S_HALT;
          err_n   = ERR_DMEM_TO;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_HALT;
      end
    endcase
  end

  // State, latched decode, wait counter, error and retire counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_FETCH;
      cls_q    <= C_R;
      alu_q    <= ALU_ADD;
      wait_cnt <= '0;
      err_q    <= ERR_NONE;
      instret  <= '0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      if (state == S_DECODE) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
      end
      if (state_n != state) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  // Output decode. Gated by RST so a reset pulse drops every request at
  // once, even one that is shorter than a clock period.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    err_code   = err_q;
    if (!RST) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_DECODE: begin
          // Jumps finish here: the target comes straight from the IR.
          if (dec_ok && dec_cls == C_J) begin
            pc_we  = 1'b1;
            pc_src = 2'd2;
          end
        end
        S_EXEC: begin
          alu_op    = alu_q;
          alu_src_b = (cls_q == C_ADDI) || (cls_q == C_LW) || (cls_q == C_SW);
          if (cls_q == C_BEQ) begin
            pc_we  = alu_zero;
            pc_src = 2'd1;
          end
        end
        S_MEM: begin
          // ALU controls stay put so the address holds for the whole access.
          dmem_req  = 1'b1;
          dmem_we   = (cls_q == C_SW);
          alu_op    = alu_q;
          alu_src_b = 1'b1;
        end
        S_WB: begin
          rf_we      = 1'b1;
          reg_dst    = (cls_q == C_R);
          mem_to_reg = (cls_q == C_LW);
          alu_op     = alu_q;
          alu_src_b  = (cls_q != C_R);
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// tb/tb_cpu_multicycle_ctrl.sv - self-checking bench for cpu_multicycle_ctrl

module tb_cpu_multicycle_ctrl;

  localparam int WMAX = 16;
  localparam int CW   = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          imem_ack, dmem_ack, alu_zero;
  logic [5:0]    opcode, funct;
  logic          imem_req, dmem_req, dmem_we, pc_we, ir_we, rf_we;
  logic          reg_dst, mem_to_reg, alu_src_b, halted;
  logic [1:0]    pc_src, err_code;
  logic [2:0]    alu_op;
  logic [CW-1:0] instret;

  cpu_multicycle_ctrl #(.WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .rf_we(rf_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .halted(halted), .err_code(err_code), .instret(instret)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          imem_req, dmem_req, dmem_we, pc_we;
    logic [1:0]    pc_src;
    logic          ir_we, rf_we, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0]    alu_op;
    logic          halted;
    logic [1:0]    err_code;
    logic [CW-1:0] instret;
  } outs_t;

  outs_t act, exp_cur;
  assign act = {imem_req, dmem_req, dmem_we, pc_we, pc_src, ir_we, rf_we, reg_dst,
                mem_to_reg, alu_src_b, alu_op, halted, err_code, instret};

  logic  exp_valid = 1'b0;
  string exp_name  = "";
  int    checks    = 0;
  int    failures  = 0;
  int    cyc       = 0;
  int    n_dreq    = 0;
  int    n_ireq    = 0;

  string lit_name [64];
  int    lit_act  [64];
  int    lit_exp  [64];
  int    lit_wr   = 0;
  int    lit_rd   = 0;

  // Model state: what the controller has architecturally done so far.
  logic [CW-1:0] m_instret;
  logic          m_halted;
  logic [1:0]    m_err;

  // Single compare process: per-cycle model outputs plus pending literal pins.
  initial begin
    forever begin
      @(negedge CLK);
      if (exp_valid) begin
        checks++;
        if (act !== exp_cur) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h want=%h", exp_name, cyc, act, exp_cur);
        end
      end
      while (lit_rd < lit_wr) begin
        checks++;
        if (lit_act[lit_rd] != lit_exp[lit_rd]) begin
          failures++;
          $display("FAIL %s got=%0d want=%0d", lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
        end
        lit_rd++;
      end
    end
  end

  task automatic lit(input string name, input int a, input int e);
    lit_name[lit_wr] = name;
    lit_act[lit_wr]  = a;
    lit_exp[lit_wr]  = e;
    lit_wr++;
  endtask

  task automatic cycle();
    exp_valid = 1'b1;
    @(negedge CLK);
    if (dmem_req) n_dreq++;
    if (imem_req) n_ireq++;
    @(posedge CLK);
    #1;
    exp_valid = 1'b0;
    cyc++;
  endtask

  function automatic outs_t base();
    outs_t o;
    o          = '0;
    o.halted   = m_halted;
    o.err_code = m_err;
    o.instret  = m_instret;
    return o;
  endfunction

  // Instruction class: 0=R 1=addi 2=lw 3=sw 4=beq 5=j, -1=illegal
  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) ? 0 : -1;
      6'h08:   return 1;
      6'h23:   return 2;
      6'h2B:   return 3;
      6'h04:   return 4;
      6'h02:   return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'd1;
      6'h24:   return 3'd2;
      6'h25:   return 3'd3;
      6'h2A:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic do_reset();
    outs_t e;
    RST       = 1'b1;
    imem_ack  = 1'b0;
    dmem_ack  = 1'b0;
    m_instret = '0;
    m_halted  = 1'b0;
    m_err     = 2'd0;
    e = base();
    exp_cur = e; exp_name = "reset"; cycle();
    exp_cur = e; exp_name = "reset"; cycle();
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = (i % 2 == 0);
      dmem_ack = (i % 3 == 0);
      exp_cur = base(); exp_name = "halt"; cycle();
    end
  endtask

  // Runs one instruction as a sequence of expected cycles. iw/dw are the ack
  // delays in cycles; mem_rst>=0 pulses RST inside MEM after that many cycles.
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input int iw,
                            input int dw, input logic z, input logic noise, input int mem_rst);
    int         c;
    logic [2:0] alu;
    outs_t      e;
    opcode   = op;
    funct    = fn;
    alu_zero = z;
    c   = cls_of(op, fn);
    alu = (c == 0) ? r_alu(fn) : ((c == 4) ? 3'd1 : 3'd0);
    for (int k = 0; k <= iw; k++) begin
      if (k == WMAX) begin
        m_halted = 1'b1; m_err = 2'd2;
        return;
      end
      imem_ack = (k == iw);
      dmem_ack = noise;
      e = base();
      e.imem_req = 1'b1;
      if (k == iw) begin
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
      end
      exp_cur = e; exp_name = "fetch"; cycle();
    end
    imem_ack = noise;
    dmem_ack = noise;
    e = base();
    if (c == 5) begin
      e.pc_we  = 1'b1;
      e.pc_src = 2'd2;
    end
    exp_cur = e; exp_name = "decode"; cycle();
    if (c < 0) begin
      m_halted = 1'b1; m_err = 2'd1;
      return;
    end
    if (c == 5) begin
      m_instret = m_instret + 1'b1;
      return;
    end
    e = base();
    e.alu_op    = alu;
    e.alu_src_b = (c == 1 || c == 2 || c == 3);
    if (c == 4) begin
      e.pc_we  = z;
      e.pc_src = 2'd1;
    end
    exp_cur = e; exp_name = "exec"; cycle();
    if (c == 4) begin
      m_instret = m_instret + 1'b1;
      return;
    end
    if (c == 2 || c == 3) begin
      for (int k = 0; k <= dw; k++) begin
        if (k == mem_rst) begin
          imem_ack  = 1'b0;
          dmem_ack  = 1'b0;
          RST       = 1'b1;
          #2;
          RST       = 1'b0;
          m_instret = '0;
          e = base();
          e.imem_req = 1'b1;
          exp_cur = e; exp_name = "rst_mid_mem"; cycle();
          return;
        end
        if (k == WMAX) begin
          m_halted = 1'b1; m_err = 2'd3;
          return;
        end
        imem_ack = noise;
        dmem_ack = (k == dw);
        e = base();
        e.dmem_req  = 1'b1;
        e.dmem_we   = (c == 3);
        e.alu_op    = 3'd0;
        e.alu_src_b = 1'b1;
        exp_cur = e; exp_name = "mem"; cycle();
      end
      if (c == 3) begin
        m_instret = m_instret + 1'b1;
        return;
      end
    end
    imem_ack = noise;
    dmem_ack = noise;
    e = base();
    e.rf_we      = 1'b1;
    e.reg_dst    = (c == 0);
    e.mem_to_reg = (c == 2);
    e.alu_op     = alu;
    e.alu_src_b  = (c != 0);
    exp_cur = e; exp_name = "wb"; cycle();
    m_instret = m_instret + 1'b1;
  endtask

  initial begin
    int c0;
    RST = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    opcode = '0; funct = '0; alu_zero = 1'b0;
    m_instret = '0; m_halted = 1'b0; m_err = 2'd0;
    @(posedge CLK);
    #1;

    do_reset();
    exec_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b0, -1);
    lit("addi_cycles", cyc, 4);
    lit("addi_instret", int'(instret), 1);

    do_reset();
    exec_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b1, -1);
    exec_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b0, -1);
    exec_instr(6'h00, 6'h20, 0, 0, 1'b0, 1'b1, -1);
    exec_instr(6'h00, 6'h22, 0, 0, 1'b0, 1'b0, -1);
    exec_instr(6'h00, 6'h24, 0, 0, 1'b0, 1'b1, -1);
    exec_instr(6'h00, 6'h25, 0, 0, 1'b0, 1'b0, -1);
    lit("prog_cycles", cyc, 24);
    lit("prog_instret", int'(instret), 6);

    c0 = cyc; n_dreq = 0;
    exec_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b1, -1);
    lit("lw_dmem_req_cycles", n_dreq, 4);
    lit("lw_cycles", cyc - c0, 8);

    exec_instr(6'h2B, 6'h00, 2, 1, 1'b0, 1'b0, -1);
    exec_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b1, -1);
    exec_instr(6'h04, 6'h00, 1, 0, 1'b0, 1'b0, -1);
    exec_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b1, -1);
    exec_instr(6'h00, 6'h2A, 0, 0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      exec_instr(6'h02, 6'h00, i % 3, 0, 1'b0, 1'b1, -1);
    end
    lit("instret_wrap", int'(instret), 2);

    exec_instr(6'h2B, 6'h00, 0, 5, 1'b0, 1'b0, 1);
    exec_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b0, -1);
    lit("after_mid_mem_rst_instret", int'(instret), 1);

    exec_instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0, -1);
    lit("illegal_err", int'(err_code), 1);
    lit("illegal_halted", int'(halted), 1);
    n_ireq = 0;
    halt_cycles(20);
    lit("halt_imem_req_cycles", n_ireq, 0);

    do_reset();
    exec_instr(6'h00, 6'h3F, 0, 0, 1'b0, 1'b1, -1);
    lit("bad_funct_err", int'(err_code), 1);
    halt_cycles(2);

    do_reset();
    exec_instr(6'h08, 6'h00, 99, 0, 1'b0, 1'b1, -1);
    lit("imem_timeout_cycles", cyc, 16);
    halt_cycles(3);
    lit("imem_timeout_err", int'(err_code), 2);
    do_reset();
    lit("err_after_reset", int'(err_code), 0);
    exec_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b0, -1);

    exec_instr(6'h23, 6'h00, 0, 99, 1'b0, 1'b1, -1);
    halt_cycles(2);
    lit("dmem_timeout_err", int'(err_code), 3);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
